// File: rtl/vote_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vote_pkg
// Brief    : Shared types and helpers for the 5-channel vote collector.
// Revision : 1.0
// ============================================================================
package vote_pkg;

    localparam int N_VOTERS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } vote_state_t;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 5; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vote_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : vote_collector_if
// Brief    : Vote inputs and collected-vector handshake of the vote collector.
// Revision : 1.0
// ============================================================================
interface vote_collector_if;
    import vote_pkg::*;

    logic                start;
    logic [N_VOTERS-1:0] vote_valid;
    logic [N_VOTERS-1:0] vote_bit;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [N_VOTERS-1:0] out_votes;
    logic [N_VOTERS-1:0] out_present;
    logic                out_timeout;
    logic                out_quorum_ok;
    logic                out_dup;

    modport master (
        output start, vote_valid, vote_bit, out_ready,
        input  busy, out_valid, out_votes, out_present,
               out_timeout, out_quorum_ok, out_dup
    );

    modport slave (
        input  start, vote_valid, vote_bit, out_ready,
        output busy, out_valid, out_votes, out_present,
               out_timeout, out_quorum_ok, out_dup
    );

endinterface
`default_nettype wire

// File: rtl/vote_collector.sv
`default_nettype none
// ============================================================================
// Module   : vote_collector
// Brief    : Collects one vote per channel within a bounded window and hands
//            the vector, presence mask and status flags to the majority stage.
// Revision : 1.0
// ============================================================================
module vote_collector
    import vote_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int QUORUM         = 3
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    vote_collector_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    vote_state_t         r_state;
    vote_state_t         w_next_state;
    logic [N_VOTERS-1:0] r_votes;
    logic [N_VOTERS-1:0] r_present;
    logic                r_dup;
    logic                r_timeout;
    logic                r_quorum_ok;
    logic [CW-1:0]       r_cnt;

    logic [N_VOTERS-1:0] w_capture;
    logic [N_VOTERS-1:0] w_votes_nxt;
    logic [N_VOTERS-1:0] w_present_nxt;
    logic                w_collect;
    logic                w_start;
    logic                w_complete;
    logic                w_expire;
    logic                w_exit;
    logic                w_dup_hit;

    assign w_collect = (r_state == COLLECT);
    assign w_start   = (r_state == IDLE) && bus.start;

    // First strobe per channel wins; later strobes only raise the dup flag.
    for (genvar i = 0; i < N_VOTERS; i++) begin : g_chan
        assign w_capture[i]   = w_collect & bus.vote_valid[i] & ~r_present[i];
        assign w_votes_nxt[i] = w_capture[i] ? bus.vote_bit[i] : r_votes[i];
    end

    assign w_present_nxt = r_present | w_capture;
    assign w_complete    = &w_present_nxt;
    assign w_expire      = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_exit        = w_collect & (w_complete | w_expire);
    assign w_dup_hit     = w_collect & (|(bus.vote_valid & r_present));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start)     w_next_state = COLLECT;
            COLLECT: if (w_exit)        w_next_state = OUTPUT;
            OUTPUT:  if (bus.out_ready) w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state != IDLE);
        bus.out_valid = (r_state == OUTPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_votes     <= '0;
            r_present   <= '0;
            r_dup       <= 1'b0;
            r_timeout   <= 1'b0;
            r_quorum_ok <= 1'b0;
            r_cnt       <= '0;
        end else if (w_start) begin
            r_votes     <= '0;
            r_present   <= '0;
            r_dup       <= 1'b0;
            r_timeout   <= 1'b0;
            r_quorum_ok <= 1'b0;
            r_cnt       <= '0;
        end else if (w_collect) begin
            r_votes   <= w_votes_nxt;
            r_present <= w_present_nxt;
            r_dup     <= r_dup | w_dup_hit;
            if (w_exit) begin
                // A vote landing on the expiry edge still completes the round.
                r_timeout   <= ~w_complete;
                r_quorum_ok <= (int'(popcount5(w_present_nxt)) >= QUORUM);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.out_votes     = r_votes;
    assign bus.out_present   = r_present;
    assign bus.out_dup       = r_dup;
    assign bus.out_timeout   = r_timeout;
    assign bus.out_quorum_ok = r_quorum_ok;

endmodule
`default_nettype wire
